// File: rtl/rx_xfer_sequencer.sv
// Receive-path read transfer sequencer: accepts one read command and waits out the dummy cycles.
// It then launches the receiver FSM and ends the transfer with rd_done, or with csr_read_end on abort or watchdog expiry.
module rx_xfer_sequencer #(
  parameter int LEN_W   = 16,
  parameter int DUMMY_W = 5,
  parameter int TO_W    = 12
) (
  input  logic               mem_clk,
  input  logic               reset_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic               cmd_ddr,
  input  logic               cmd_dlp,
  input  logic [DUMMY_W-1:0] cmd_dummy,
  input  logic [TO_W-1:0]    csr_timeout,
  input  logic               abort,
  input  logic               dlp_read_stop,
  input  logic               rx_beat_valid,
  output logic               ddr_en,
  output logic               instrn_dlp_en,
  output logic               read_instrn,
  output logic               rd_done,
  output logic               csr_read_end,
  output logic               busy,
  output logic               timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DUMMY,
    S_TRAIN,
    S_DATA,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [DUMMY_W-1:0] dummy_cnt_q, dummy_cnt_d;
  logic [LEN_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [TO_W-1:0]    wd_cnt_q, wd_cnt_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               ddr_q, ddr_d;
  logic               dlp_q, dlp_d;
  logic               ddr_en_q, ddr_en_d;
  logic               instrn_dlp_en_q, instrn_dlp_en_d;
  logic               read_instrn_q, read_instrn_d;
  logic               rd_done_q, rd_done_d;
  logic               csr_read_end_q, csr_read_end_d;
  logic               busy_q, busy_d;
  logic               cmd_ready_q, cmd_ready_d;
  logic               timeout_err_q, timeout_err_d;

  logic               launch;
  logic [LEN_W-1:0]   launch_len;
  logic               launch_ddr;
  logic               launch_dlp;
  logic [TO_W:0]      wd_sum;
  logic               wd_expire;

  always_comb begin
    state_d         = state_q;
    dummy_cnt_d     = dummy_cnt_q;
    beat_cnt_d      = beat_cnt_q;
    wd_cnt_d        = wd_cnt_q;
    len_d           = len_q;
    ddr_d           = ddr_q;
    dlp_d           = dlp_q;
    ddr_en_d        = ddr_en_q;
    instrn_dlp_en_d = instrn_dlp_en_q;
    read_instrn_d   = 1'b0;
    rd_done_d       = 1'b0;
    csr_read_end_d  = 1'b0;
    timeout_err_d   = timeout_err_q;
    launch          = 1'b0;
    launch_len      = len_q;
    launch_ddr      = ddr_q;
    launch_dlp      = dlp_q;
    // Extra bit keeps the compare exact at the top of the counter range.
    wd_sum    = {1'b0, wd_cnt_q} + {{TO_W{1'b0}}, 1'b1};
    wd_expire = (csr_timeout != '0) && (wd_sum >= {1'b0, csr_timeout});

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          len_d         = cmd_len;
          ddr_d         = cmd_ddr;
          dlp_d         = cmd_dlp & cmd_ddr;
          timeout_err_d = 1'b0;
          launch_len    = cmd_len;
          launch_ddr    = cmd_ddr;
          launch_dlp    = cmd_dlp & cmd_ddr;
          if (cmd_dummy != '0) begin
            dummy_cnt_d = cmd_dummy;
            state_d     = S_DUMMY;
          end else begin
            launch = 1'b1;
          end
        end
      end
      S_DUMMY: begin
        if (abort) begin
          csr_read_end_d = 1'b1;
          state_d        = S_DONE;
        end else if (dummy_cnt_q == DUMMY_W'(1)) begin
          dummy_cnt_d = '0;
          launch      = 1'b1;
        end else begin
          dummy_cnt_d = dummy_cnt_q - DUMMY_W'(1);
        end
      end
      S_TRAIN: begin
        if (abort) begin
          csr_read_end_d = 1'b1;
          state_d        = S_DONE;
        end else if (dlp_read_stop) begin
          beat_cnt_d = len_q;
          wd_cnt_d   = '0;
          state_d    = S_DATA;
        end else if (wd_expire) begin
          csr_read_end_d = 1'b1;
          timeout_err_d  = 1'b1;
          state_d        = S_DONE;
        end else begin
          wd_cnt_d = wd_sum[TO_W-1:0];
        end
      end
      S_DATA: begin
        // The final beat outranks a simultaneous abort or watchdog expiry.
        if (rx_beat_valid && (beat_cnt_q == '0)) begin
          rd_done_d = 1'b1;
          state_d   = S_DONE;
        end else if (abort) begin
          csr_read_end_d = 1'b1;
          state_d        = S_DONE;
        end else if (rx_beat_valid) begin
          beat_cnt_d = beat_cnt_q - LEN_W'(1);
          wd_cnt_d   = '0;
        end else if (wd_expire) begin
          csr_read_end_d = 1'b1;
          timeout_err_d  = 1'b1;
          state_d        = S_DONE;
        end else begin
          wd_cnt_d = wd_sum[TO_W-1:0];
        end
      end
      S_DONE: begin
        ddr_en_d        = 1'b0;
        instrn_dlp_en_d = 1'b0;
        state_d         = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (launch) begin
      read_instrn_d   = 1'b1;
      ddr_en_d        = launch_ddr;
      instrn_dlp_en_d = launch_dlp;
      beat_cnt_d      = launch_len;
      wd_cnt_d        = '0;
      state_d         = launch_dlp ? S_TRAIN : S_DATA;
    end

    busy_d      = (state_d != S_IDLE);
    cmd_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge mem_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= S_IDLE;
      dummy_cnt_q     <= '0;
      beat_cnt_q      <= '0;
      wd_cnt_q        <= '0;
      len_q           <= '0;
      ddr_q           <= 1'b0;
      dlp_q           <= 1'b0;
      ddr_en_q        <= 1'b0;
      instrn_dlp_en_q <= 1'b0;
      read_instrn_q   <= 1'b0;
      rd_done_q       <= 1'b0;
      csr_read_end_q  <= 1'b0;
      busy_q          <= 1'b0;
      cmd_ready_q     <= 1'b1;
      timeout_err_q   <= 1'b0;
    end else begin
      state_q         <= state_d;
      dummy_cnt_q     <= dummy_cnt_d;
      beat_cnt_q      <= beat_cnt_d;
      wd_cnt_q        <= wd_cnt_d;
      len_q           <= len_d;
      ddr_q           <= ddr_d;
      dlp_q           <= dlp_d;
      ddr_en_q        <= ddr_en_d;
      instrn_dlp_en_q <= instrn_dlp_en_d;
      read_instrn_q   <= read_instrn_d;
      rd_done_q       <= rd_done_d;
      csr_read_end_q  <= csr_read_end_d;
      busy_q          <= busy_d;
      cmd_ready_q     <= cmd_ready_d;
      timeout_err_q   <= timeout_err_d;
    end
  end

  assign cmd_ready     = cmd_ready_q;
  assign ddr_en        = ddr_en_q;
  assign instrn_dlp_en = instrn_dlp_en_q;
  assign read_instrn   = read_instrn_q;
  assign rd_done       = rd_done_q;
  assign csr_read_end  = csr_read_end_q;
  assign busy          = busy_q;
  assign timeout_err   = timeout_err_q;

endmodule

// File: tb/tb_rx_xfer_sequencer.sv
// Directed bench for rx_xfer_sequencer: launch latency, beat counting, training, watchdog,
// abort priority, back-to-back commands and asynchronous reset mid-transfer.
module tb_rx_xfer_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_len;
  logic        cmd_ddr;
  logic        cmd_dlp;
  logic [4:0]  cmd_dummy;
  logic [11:0] csr_timeout;
  logic        abort;
  logic        dlp_read_stop;
  logic        rx_beat_valid;
  logic        ddr_en;
  logic        instrn_dlp_en;
  logic        read_instrn;
  logic        rd_done;
  logic        csr_read_end;
  logic        busy;
  logic        timeout_err;

  int checks = 0;
  int failures = 0;

  rx_xfer_sequencer #(.LEN_W(16), .DUMMY_W(5), .TO_W(12)) dut (
    .mem_clk       (clk),
    .reset_n       (reset_n),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_len       (cmd_len),
    .cmd_ddr       (cmd_ddr),
    .cmd_dlp       (cmd_dlp),
    .cmd_dummy     (cmd_dummy),
    .csr_timeout   (csr_timeout),
    .abort         (abort),
    .dlp_read_stop (dlp_read_stop),
    .rx_beat_valid (rx_beat_valid),
    .ddr_en        (ddr_en),
    .instrn_dlp_en (instrn_dlp_en),
    .read_instrn   (read_instrn),
    .rd_done       (rd_done),
    .csr_read_end  (csr_read_end),
    .busy          (busy),
    .timeout_err   (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [15:0] len, input logic ddr, input logic dlp,
                       input logic [4:0] dummy);
    cmd_valid = 1'b1;
    cmd_len   = len;
    cmd_ddr   = ddr;
    cmd_dlp   = dlp;
    cmd_dummy = dummy;
    tick();
    cmd_valid = 1'b0;
    cmd_len   = 16'hffff;
    cmd_ddr   = 1'b0;
    cmd_dlp   = 1'b0;
    cmd_dummy = 5'd0;
  endtask

  task automatic test_reset();
    logic [7:0] outs;
    reset_n = 1'b0;
    tick();
    tick();
    outs = {cmd_ready, busy, ddr_en, instrn_dlp_en, read_instrn, rd_done, csr_read_end, timeout_err};
    checks++;
    if (outs !== 8'b1000_0000) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=10000000", outs);
    end
    reset_n = 1'b1;
    tick();
    outs = {cmd_ready, busy, ddr_en, instrn_dlp_en, read_instrn, rd_done, csr_read_end, timeout_err};
    checks++;
    if (outs !== 8'b1000_0000) begin
      failures++;
      $display("FAIL post_reset_idle got=%b exp=10000000", outs);
    end
    $display("test_reset: outputs=%b", outs);
  endtask

  task automatic test_basic();
    issue(16'd3, 1'b0, 1'b0, 5'd0);
    checks++;
    if ({read_instrn, busy, cmd_ready, ddr_en} !== 4'b1100) begin
      failures++;
      $display("FAIL basic_launch got=%b exp=1100", {read_instrn, busy, cmd_ready, ddr_en});
    end
    rx_beat_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      checks++;
      if (rd_done !== (i == 4)) begin
        failures++;
        $display("FAIL basic_rd_done beat=%0d got=%b exp=%b", i, rd_done, (i == 4));
      end
      if (i == 1) begin
        checks++;
        if (read_instrn !== 1'b0) begin
          failures++;
          $display("FAIL basic_read_instrn_width got=%b exp=0", read_instrn);
        end
      end
    end
    rx_beat_valid = 1'b0;
    checks++;
    if ({busy, cmd_ready, csr_read_end} !== 3'b100) begin
      failures++;
      $display("FAIL basic_done_state got=%b exp=100", {busy, cmd_ready, csr_read_end});
    end
    tick();
    checks++;
    if ({rd_done, busy, cmd_ready} !== 3'b001) begin
      failures++;
      $display("FAIL basic_back_idle got=%b exp=001", {rd_done, busy, cmd_ready});
    end
    $display("test_basic: len=3 ddr=0 dlp=0 dummy=0 complete");
  endtask

  task automatic test_dlp_dummy();
    int n;
    int beats;
    issue(16'd2, 1'b1, 1'b1, 5'd4);
    n = 0;
    while (read_instrn !== 1'b1 && n < 20) begin
      checks++;
      if ({busy, ddr_en} !== 2'b10) begin
        failures++;
        $display("FAIL dummy_phase got=%b exp=10", {busy, ddr_en});
      end
      tick();
      n++;
    end
    checks++;
    if (n != 4) begin
      failures++;
      $display("FAIL dummy_latency got=%0d exp=4", n);
    end
    checks++;
    if ({ddr_en, instrn_dlp_en} !== 2'b11) begin
      failures++;
      $display("FAIL dlp_levels got=%b exp=11", {ddr_en, instrn_dlp_en});
    end
    rx_beat_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (rd_done !== 1'b0) begin
        failures++;
        $display("FAIL train_ignores_beats cycle=%0d got=%b exp=0", i, rd_done);
      end
    end
    rx_beat_valid = 1'b0;
    dlp_read_stop = 1'b1;
    tick();
    dlp_read_stop = 1'b0;
    rx_beat_valid = 1'b1;
    beats = 0;
    while (rd_done !== 1'b1 && beats < 10) begin
      tick();
      beats++;
    end
    rx_beat_valid = 1'b0;
    checks++;
    if (beats != 3) begin
      failures++;
      $display("FAIL dlp_beat_count got=%0d exp=3", beats);
    end
    checks++;
    if ({ddr_en, instrn_dlp_en} !== 2'b11) begin
      failures++;
      $display("FAIL done_levels_held got=%b exp=11", {ddr_en, instrn_dlp_en});
    end
    tick();
    checks++;
    if ({ddr_en, instrn_dlp_en, cmd_ready} !== 3'b001) begin
      failures++;
      $display("FAIL levels_drop got=%b exp=001", {ddr_en, instrn_dlp_en, cmd_ready});
    end
    $display("test_dlp_dummy: latency=%0d beats=%0d", n, beats);
  endtask

  task automatic test_timeout();
    int n;
    csr_timeout = 12'd10;
    issue(16'd5, 1'b0, 1'b0, 5'd0);
    n = 0;
    while (csr_read_end !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
    checks++;
    if (n != 10) begin
      failures++;
      $display("FAIL timeout_cycles got=%0d exp=10", n);
    end
    checks++;
    if ({timeout_err, rd_done} !== 2'b10) begin
      failures++;
      $display("FAIL timeout_flags got=%b exp=10", {timeout_err, rd_done});
    end
    tick();
    tick();
    checks++;
    if ({timeout_err, csr_read_end, cmd_ready} !== 3'b101) begin
      failures++;
      $display("FAIL timeout_sticky got=%b exp=101", {timeout_err, csr_read_end, cmd_ready});
    end
    issue(16'd0, 1'b0, 1'b0, 5'd0);
    checks++;
    if (timeout_err !== 1'b0) begin
      failures++;
      $display("FAIL timeout_clear got=%b exp=0", timeout_err);
    end
    rx_beat_valid = 1'b1;
    tick();
    rx_beat_valid = 1'b0;
    checks++;
    if ({rd_done, csr_read_end} !== 2'b10) begin
      failures++;
      $display("FAIL post_timeout_xfer got=%b exp=10", {rd_done, csr_read_end});
    end
    tick();
    csr_timeout = 12'd0;
    $display("test_timeout: expiry after %0d idle cycles", n);
  endtask

  task automatic test_abort();
    int ends;
    int launches;
    issue(16'd1, 1'b0, 1'b0, 5'd0);
    rx_beat_valid = 1'b1;
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    rx_beat_valid = 1'b0;
    checks++;
    if ({rd_done, csr_read_end} !== 2'b10) begin
      failures++;
      $display("FAIL abort_vs_last_beat got=%b exp=10", {rd_done, csr_read_end});
    end
    ends = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (csr_read_end === 1'b1) ends++;
    end
    checks++;
    if (ends != 0) begin
      failures++;
      $display("FAIL abort_late_end got=%0d exp=0", ends);
    end
    issue(16'd7, 1'b1, 1'b0, 5'd5);
    tick();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if ({csr_read_end, read_instrn, timeout_err, busy} !== 4'b1001) begin
      failures++;
      $display("FAIL abort_dummy got=%b exp=1001", {csr_read_end, read_instrn, timeout_err, busy});
    end
    launches = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (read_instrn === 1'b1) launches++;
    end
    checks++;
    if (launches != 0 || cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL abort_dummy_no_launch got=%0d ready=%b exp=0 ready=1", launches, cmd_ready);
    end
    $display("test_abort: coincident and dummy-phase aborts done");
  endtask

  task automatic test_back_to_back();
    int n;
    cmd_valid     = 1'b1;
    cmd_len       = 16'd0;
    cmd_ddr       = 1'b0;
    cmd_dlp       = 1'b0;
    cmd_dummy     = 5'd0;
    rx_beat_valid = 1'b1;
    tick();
    checks++;
    if (read_instrn !== 1'b1) begin
      failures++;
      $display("FAIL b2b_first_launch got=%b exp=1", read_instrn);
    end
    tick();
    checks++;
    if (rd_done !== 1'b1) begin
      failures++;
      $display("FAIL b2b_single_beat got=%b exp=1", rd_done);
    end
    n = 0;
    do begin
      tick();
      n++;
    end while (read_instrn !== 1'b1 && n < 10);
    checks++;
    if (n != 2) begin
      failures++;
      $display("FAIL b2b_gap got=%0d exp=2", n);
    end
    tick();
    cmd_valid     = 1'b0;
    rx_beat_valid = 1'b0;
    checks++;
    if (rd_done !== 1'b1) begin
      failures++;
      $display("FAIL b2b_second_done got=%b exp=1", rd_done);
    end
    tick();
    tick();
    checks++;
    if ({busy, read_instrn} !== 2'b00) begin
      failures++;
      $display("FAIL b2b_no_third got=%b exp=00", {busy, read_instrn});
    end
    $display("test_back_to_back: gap=%0d", n);
  endtask

  task automatic test_reset_mid();
    int pulses;
    logic [7:0] outs;
    issue(16'd10, 1'b1, 1'b0, 5'd0);
    rx_beat_valid = 1'b1;
    tick();
    tick();
    tick();
    rx_beat_valid = 1'b0;
    checks++;
    if ({ddr_en, busy} !== 2'b11) begin
      failures++;
      $display("FAIL pre_reset_active got=%b exp=11", {ddr_en, busy});
    end
    #2;
    reset_n = 1'b0;
    #1;
    outs = {cmd_ready, busy, ddr_en, instrn_dlp_en, read_instrn, rd_done, csr_read_end, timeout_err};
    checks++;
    if (outs !== 8'b1000_0000) begin
      failures++;
      $display("FAIL reset_mid_async got=%b exp=10000000", outs);
    end
    pulses = 0;
    tick();
    if (rd_done === 1'b1 || csr_read_end === 1'b1) pulses++;
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (rd_done === 1'b1 || csr_read_end === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0 || cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_silent got=%0d ready=%b exp=0 ready=1", pulses, cmd_ready);
    end
    $display("test_reset_mid: outputs=%b", outs);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout got=hang exp=finish");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    reset_n       = 1'b0;
    cmd_valid     = 1'b0;
    cmd_len       = 16'd0;
    cmd_ddr       = 1'b0;
    cmd_dlp       = 1'b0;
    cmd_dummy     = 5'd0;
    csr_timeout   = 12'd0;
    abort         = 1'b0;
    dlp_read_stop = 1'b0;
    rx_beat_valid = 1'b0;
    test_reset();
    test_basic();
    test_dlp_dummy();
    test_timeout();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
